// File: rtl/user_id_bank.sv
// Multi-word mask-programmed ID bank: registered parallel read port, MSB-first
// serial shift-out port, and an XOR checksum of all words computed after reset.
module user_id_bank #(
  parameter int                          NUM_WORDS       = 4,
  parameter int                          WORD_W          = 32,
  parameter int                          ADDR_W          = 2,
  parameter logic [NUM_WORDS*WORD_W-1:0] USER_PROJECT_ID = '0
) (
`ifdef USE_POWER_PINS
  inout  wire               vccd1,
  inout  wire               vssd1,
`endif
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_ack_o,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_err_o,
  input  logic              sh_start_i,
  input  logic [ADDR_W-1:0] sh_addr_i,
  output logic              sh_data_o,
  output logic              sh_valid_o,
  output logic              sh_busy_o,
  output logic              sh_done_o,
  output logic              init_done_o,
  output logic [WORD_W-1:0] checksum_o,
  output logic [WORD_W-1:0] mask_rev_o
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SHIFT} state_t;

  // Out-of-range indices read as zero, which also gives the zero shift pattern.
  function automatic logic [WORD_W-1:0] word_at(input logic [ADDR_W-1:0] k);
    word_at = '0;
    for (int i = 0; i < NUM_WORDS; i++)
      if (int'(k) == i) word_at = USER_PROJECT_ID[i*WORD_W +: WORD_W];
  endfunction

  state_t              r_state,     w_state_nxt;
  logic [IDX_W-1:0]    r_idx,       w_idx_nxt;
  logic [WORD_W-1:0]   r_acc,       w_acc_nxt;
  logic [WORD_W-1:0]   r_checksum,  w_checksum_nxt;
  logic                r_init_done, w_init_done_nxt;
  logic                r_rd_ack,    w_rd_ack_nxt;
  logic [WORD_W-1:0]   r_rd_data,   w_rd_data_nxt;
  logic                r_rd_err,    w_rd_err_nxt;
  logic [WORD_W-1:0]   r_shreg,     w_shreg_nxt;
  logic [CNT_W-1:0]    r_cnt,       w_cnt_nxt;
  logic                r_sh_busy,   w_sh_busy_nxt;
  logic                r_sh_done,   w_sh_done_nxt;
  logic                w_rd_in_range;

  assign w_rd_in_range = (int'(rd_addr_i) < NUM_WORDS);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_acc_nxt       = r_acc;
    w_checksum_nxt  = r_checksum;
    w_init_done_nxt = r_init_done;
    w_rd_ack_nxt    = 1'b0;
    w_rd_data_nxt   = r_rd_data;
    w_rd_err_nxt    = r_rd_err;
    w_shreg_nxt     = r_shreg;
    w_cnt_nxt       = r_cnt;
    w_sh_busy_nxt   = r_sh_busy;
    w_sh_done_nxt   = 1'b0;

    case (r_state)
      S_INIT: begin
        w_acc_nxt = r_acc ^ word_at(ADDR_W'(r_idx));
        if (r_idx == IDX_W'(NUM_WORDS - 1)) begin
          w_checksum_nxt  = w_acc_nxt;
          w_init_done_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end

      S_IDLE: begin
        // The ack cycle itself never accepts, limiting reads to one per two cycles.
        if (rd_req_i && !r_rd_ack) begin
          w_rd_ack_nxt  = 1'b1;
          w_rd_data_nxt = word_at(rd_addr_i);
          w_rd_err_nxt  = !w_rd_in_range;
        end else if (sh_start_i && !rd_req_i) begin
          w_shreg_nxt   = word_at(sh_addr_i);
          w_cnt_nxt     = CNT_W'(WORD_W - 1);
          w_sh_busy_nxt = 1'b1;
          w_state_nxt   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_shreg_nxt = r_shreg << 1;
        if (r_cnt == '0) begin
          w_sh_busy_nxt = 1'b0;
          w_sh_done_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      default: w_state_nxt = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_INIT;
      r_idx       <= '0;
      r_acc       <= '0;
      r_checksum  <= '0;
      r_init_done <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_rd_data   <= '0;
      r_rd_err    <= 1'b0;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_sh_busy   <= 1'b0;
      r_sh_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_acc       <= w_acc_nxt;
      r_checksum  <= w_checksum_nxt;
      r_init_done <= w_init_done_nxt;
      r_rd_ack    <= w_rd_ack_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_err    <= w_rd_err_nxt;
      r_shreg     <= w_shreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sh_busy   <= w_sh_busy_nxt;
      r_sh_done   <= w_sh_done_nxt;
    end
  end

  assign rd_ack_o    = r_rd_ack;
  assign rd_data_o   = r_rd_data;
  assign rd_err_o    = r_rd_err;
  assign sh_valid_o  = (r_state == S_SHIFT);
  assign sh_data_o   = sh_valid_o & r_shreg[WORD_W-1];
  assign sh_busy_o   = r_sh_busy;
  assign sh_done_o   = r_sh_done;
  assign init_done_o = r_init_done;
  assign checksum_o  = r_checksum;
  assign mask_rev_o  = USER_PROJECT_ID[WORD_W-1:0];

endmodule

// File: tb/tb_user_id_bank.sv
// Scoreboard bench for user_id_bank: stimulus queues expected read words and shift
// bits; a negedge monitor pops and compares whenever the DUT presents them.
module tb_user_id_bank;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, sh_start;
  logic [1:0]  rd_addr, sh_addr;
  logic        rd_ack, rd_err, sh_data, sh_valid, sh_busy, sh_done, init_done;
  logic [31:0] rd_data, checksum, mask_rev;

  logic        rd_req_b;
  logic [1:0]  rd_addr_b;
  logic        rd_ack_b, rd_err_b, sh_data_b, sh_valid_b, sh_busy_b, sh_done_b, init_done_b;
  logic [31:0] rd_data_b, checksum_b, mask_rev_b;

  rd_exp_t     rd_q[$];
  logic        sh_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  int          exp_done = 0;

  always #5 clk = ~clk;

  user_id_bank #(
    .NUM_WORDS(4), .WORD_W(32), .ADDR_W(2),
    .USER_PROJECT_ID(128'hDEADBEEF_12345678_A5A5A5A5_000000FF)
  ) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack),
    .rd_data_o(rd_data), .rd_err_o(rd_err),
    .sh_start_i(sh_start), .sh_addr_i(sh_addr), .sh_data_o(sh_data),
    .sh_valid_o(sh_valid), .sh_busy_o(sh_busy), .sh_done_o(sh_done),
    .init_done_o(init_done), .checksum_o(checksum), .mask_rev_o(mask_rev)
  );

  user_id_bank #(
    .NUM_WORDS(3), .WORD_W(32), .ADDR_W(2),
    .USER_PROJECT_ID(96'h12345678_A5A5A5A5_000000FF)
  ) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .rd_req_i(rd_req_b), .rd_addr_i(rd_addr_b), .rd_ack_o(rd_ack_b),
    .rd_data_o(rd_data_b), .rd_err_o(rd_err_b),
    .sh_start_i(1'b0), .sh_addr_i(2'd0), .sh_data_o(sh_data_b),
    .sh_valid_o(sh_valid_b), .sh_busy_o(sh_busy_b), .sh_done_o(sh_done_b),
    .init_done_o(init_done_b), .checksum_o(checksum_b), .mask_rev_o(mask_rev_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_shift(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) sh_q.push_back(w[31-i]);
  endtask

  task automatic exp_read(input logic [31:0] d, input logic e);
    rd_exp_t x;
    x.data = d;
    x.err  = e;
    rd_q.push_back(x);
  endtask

  // init_done must rise on exactly the fourth edge after reset release.
  task automatic wait_init(input string tag);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check({tag, "_init_done"}, 32'(init_done), 32'(k == 4));
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read ack or shift bit.
  always @(negedge clk) begin
    if (rd_ack) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: got ack data %h with no read outstanding", rd_data);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check("rd_data", rd_data, e.data);
        check("rd_err", 32'(rd_err), 32'(e.err));
      end
    end
    if (sh_valid) begin
      if (sh_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sh_unexpected: got valid bit %b with no shift outstanding", sh_data);
      end else begin
        check("sh_bit", 32'(sh_data), 32'(sh_q.pop_front()));
      end
    end else begin
      check("sh_data_idle", 32'(sh_data), 32'd0);
    end
    if (sh_done) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] words [4];
    words[0] = 32'h000000FF;
    words[1] = 32'hA5A5A5A5;
    words[2] = 32'h12345678;
    words[3] = 32'hDEADBEEF;

    rst = 1'b1; rd_req = 1'b0; sh_start = 1'b0; rd_addr = '0; sh_addr = '0;
    rd_req_b = 1'b0; rd_addr_b = '0;

    // Reset state
    repeat (2) tick();
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_busy", 32'(sh_busy), 32'd0);
    check("rst_mask_rev", mask_rev, 32'h000000FF);

    // Checksum sequence after release
    rst = 1'b0;
    wait_init("init1");
    check("checksum", checksum, 32'h693C4DCD);
    check("checksum_n3", checksum_b, 32'hB791F322);
    check("mask_rev", mask_rev, 32'h000000FF);

    // Single reads of every word, one-cycle latency
    for (int a = 0; a < 4; a++) begin
      rd_addr = a[1:0];
      rd_req  = 1'b1;
      exp_read(words[a], 1'b0);
      tick();
      check("rd_lat", 32'(rd_ack), 32'd1);
      rd_req = 1'b0;
      tick();
      check("rd_ack_pulse", 32'(rd_ack), 32'd0);
    end

    // Held request: acks two cycles apart
    rd_addr = 2'd3;
    rd_req  = 1'b1;
    exp_read(32'hDEADBEEF, 1'b0);
    exp_read(32'hDEADBEEF, 1'b0);
    tick(); check("held_ack1", 32'(rd_ack), 32'd1);
    tick(); check("held_gap", 32'(rd_ack), 32'd0);
    tick(); check("held_ack2", 32'(rd_ack), 32'd1);
    rd_req = 1'b0;
    tick(); check("held_end", 32'(rd_ack), 32'd0);

    // Shift word 1
    sh_addr  = 2'd1;
    sh_start = 1'b1;
    exp_shift(32'hA5A5A5A5, 32);
    exp_done++;
    tick();
    check("sh_busy_rise", 32'(sh_busy), 32'd1);
    sh_start = 1'b0;
    repeat (31) tick();
    check("sh_last_valid", 32'(sh_valid), 32'd1);
    check("sh_last_done", 32'(sh_done), 32'd0);
    tick();
    check("sh_done", 32'(sh_done), 32'd1);
    check("sh_done_busy", 32'(sh_busy), 32'd0);
    check("sh_done_valid", 32'(sh_valid), 32'd0);
    tick();
    check("sh_done_pulse", 32'(sh_done), 32'd0);

    // Held start restarts right after done, picking up the new address
    sh_addr  = 2'd3;
    sh_start = 1'b1;
    exp_shift(32'hDEADBEEF, 32);
    exp_shift(32'h000000FF, 32);
    exp_done += 2;
    repeat (33) tick();
    check("rs_done", 32'(sh_done), 32'd1);
    sh_addr = 2'd0;
    tick();
    check("rs_busy", 32'(sh_busy), 32'd1);
    check("rs_valid", 32'(sh_valid), 32'd1);
    sh_start = 1'b0;
    repeat (32) tick();
    check("rs_done2", 32'(sh_done), 32'd1);
    tick();

    // Read wins a tie; read during shift waits for done
    rd_addr  = 2'd2;
    sh_addr  = 2'd1;
    rd_req   = 1'b1;
    sh_start = 1'b1;
    exp_read(32'h12345678, 1'b0);
    exp_shift(32'hA5A5A5A5, 32);
    exp_done++;
    tick();
    check("tie_ack", 32'(rd_ack), 32'd1);
    check("tie_busy", 32'(sh_busy), 32'd0);
    rd_req = 1'b0;
    tick();
    check("tie_sh_start", 32'(sh_busy), 32'd1);
    sh_start = 1'b0;
    rd_addr  = 2'd0;
    rd_req   = 1'b1;
    exp_read(32'h000000FF, 1'b0);
    repeat (31) begin
      tick();
      check("rd_stall", 32'(rd_ack), 32'd0);
    end
    tick();
    check("stall_done", 32'(sh_done), 32'd1);
    check("stall_done_ack", 32'(rd_ack), 32'd0);
    tick();
    check("stall_ack", 32'(rd_ack), 32'd1);
    rd_req = 1'b0;
    tick();

    // Reset at bit 10 of a shift
    sh_addr  = 2'd3;
    sh_start = 1'b1;
    exp_shift(32'hDEADBEEF, 11);
    tick();
    sh_start = 1'b0;
    repeat (10) tick();
    check("abort_valid", 32'(sh_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_valid0", 32'(sh_valid), 32'd0);
    check("abort_busy", 32'(sh_busy), 32'd0);
    check("abort_done", 32'(sh_done), 32'd0);
    check("abort_init", 32'(init_done), 32'd0);
    check("abort_checksum", checksum, 32'd0);
    check("abort_rd_data", rd_data, 32'd0);
    check("abort_mask_rev", mask_rev, 32'h000000FF);
    rst = 1'b0;
    wait_init("init2");
    check("checksum2", checksum, 32'h693C4DCD);

    // Three-word instance: in-range read then out-of-range read
    rd_addr_b = 2'd2;
    rd_req_b  = 1'b1;
    tick();
    check("n3_ack", 32'(rd_ack_b), 32'd1);
    check("n3_data", rd_data_b, 32'h12345678);
    check("n3_err", 32'(rd_err_b), 32'd0);
    rd_req_b  = 1'b0;
    rd_addr_b = 2'd3;
    tick();
    rd_req_b = 1'b1;
    tick();
    check("oor_ack", 32'(rd_ack_b), 32'd1);
    check("oor_err", 32'(rd_err_b), 32'd1);
    check("oor_data", rd_data_b, 32'd0);
    rd_req_b = 1'b0;
    repeat (2) tick();

    check("done_count", 32'(n_done), 32'(exp_done));
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("sh_q_empty", 32'(sh_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
